keypad_emulator: RTL and testbench

Responder side of the 4x4 keypad scan interface: models a physical hex keypad so the column-scanning keypad reader can be exercised on-chip or in simulation without a real keypad. It accepts queued key-press commands (key code plus hold time) and returns row levels in response to the reader's column drive. Each press lasts a programmed number of cycles and is followed by a fixed all-released gap. It sits between a stimulus/test controller and the reader's `rows`/`cols` pins, in loopback mode.

---
 rtl/keypad_emulator_if.sv | 13 +
 rtl/keypad_emulator.sv | 175 +++++++++++++++++
 tb/tb_keypad_emulator.sv | 196 +++++++++++++++++++
 3 files changed

// File: rtl/keypad_emulator_if.sv
// Command handshake between a stimulus controller and keypad_emulator.
// The master queues {key, hold} commands; the slave (emulator) returns cmd_ready.
interface keypad_emulator_if #(
    parameter int HOLDBITS = 8
);
    logic                cmd_valid;
    logic [3:0]          cmd_key;
    logic [HOLDBITS-1:0] cmd_hold;
    logic                cmd_ready;

    modport master (output cmd_valid, output cmd_key, output cmd_hold, input cmd_ready);
    modport slave  (input cmd_valid, input cmd_key, input cmd_hold, output cmd_ready);
endinterface

// File: rtl/keypad_emulator.sv
// 4x4 hex keypad responder: queued key presses drive rows back against the reader's column scan.
// Optional contact bounce on the first PRESS cycles when KEYEMU_BOUNCE_EN is defined.
module keypad_emulator #(
    parameter int DEPTH     = 4,
    parameter int HOLDBITS  = 8,
    parameter int GAPCYCLES = 16
) (
    input  logic               clk1,
    input  logic               reset,
    keypad_emulator_if.slave   cmd,
    input  logic [3:0]         cols,
    output logic [3:0]         rows,
    output logic               key_active,
    output logic               busy,
    output logic               done
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam int GW = $clog2(GAPCYCLES) + 1;

    typedef enum logic [1:0] {S_IDLE, S_PRESS, S_RELEASE} state_e;

    state_e              state_q, state_d;
    logic [3:0]          key_q, key_d;
    logic [HOLDBITS-1:0] hold_q, hold_d;
    logic [GW-1:0]       gap_q, gap_d;
    logic                done_q, done_d;

    logic [PW-1:0]       wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]       count_q;
    logic [3:0]          key_mem_q  [DEPTH];
    logic [HOLDBITS-1:0] hold_mem_q [DEPTH];

    logic                full, push, pop;
    logic [HOLDBITS-1:0] head_hold;
    logic [3:0]          col_mask, row_mask;

`ifdef KEYEMU_BOUNCE_EN
    logic [2:0]          bcnt_q, bcnt_d;
    logic                tog_q, tog_d;
`endif

    assign full      = (count_q == CW'(DEPTH));
    assign push      = cmd.cmd_valid & ~full;
    assign pop       = (state_q == S_IDLE) && (count_q != '0);
    assign head_hold = hold_mem_q[rd_ptr_q];

    always_ff @(posedge clk1 or negedge reset) begin
        if (!reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + PW'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
            case ({push, pop})
                2'b10:   count_q <= count_q + CW'(1);
                2'b01:   count_q <= count_q - CW'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    always_ff @(posedge clk1) begin
        if (push) begin
            key_mem_q[wr_ptr_q]  <= cmd.cmd_key;
            hold_mem_q[wr_ptr_q] <= cmd.cmd_hold;
        end
    end

    always_ff @(posedge clk1 or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            key_q   <= '0;
            hold_q  <= '0;
            gap_q   <= '0;
            done_q  <= 1'b0;
`ifdef KEYEMU_BOUNCE_EN
            bcnt_q  <= '0;
            tog_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            key_q   <= key_d;
            hold_q  <= hold_d;
            gap_q   <= gap_d;
            done_q  <= done_d;
`ifdef KEYEMU_BOUNCE_EN
            bcnt_q  <= bcnt_d;
            tog_q   <= tog_d;
`endif
        end
    end

    always_comb begin
        state_d = state_q;
        key_d   = key_q;
        hold_d  = hold_q;
        gap_d   = gap_q;
        done_d  = 1'b0;
`ifdef KEYEMU_BOUNCE_EN
        bcnt_d  = bcnt_q;
        tog_d   = ~tog_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (count_q != '0) begin
                    key_d   = key_mem_q[rd_ptr_q];
                    // a zero hold still yields one PRESS cycle
                    hold_d  = (head_hold == '0) ? '0 : head_hold - HOLDBITS'(1);
                    state_d = S_PRESS;
`ifdef KEYEMU_BOUNCE_EN
                    bcnt_d  = '0;
                    tog_d   = 1'b0;
`endif
                end
            end
            S_PRESS: begin
`ifdef KEYEMU_BOUNCE_EN
                if (bcnt_q != 3'd4) bcnt_d = bcnt_q + 3'd1;
`endif
                if (hold_q == '0) begin
                    gap_d   = GW'(GAPCYCLES - 1);
                    state_d = S_RELEASE;
                end else begin
                    hold_d  = hold_q - HOLDBITS'(1);
                end
            end
            S_RELEASE: begin
                if (gap_q == '0) begin
                    done_d  = 1'b1;
                    state_d = S_IDLE;
                end else begin
                    gap_d   = gap_q - GW'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        col_mask = '0;
        row_mask = '0;
        case (key_q)
            4'h1: begin col_mask = 4'b1000; row_mask = 4'b1000; end
            4'h4: begin col_mask = 4'b1000; row_mask = 4'b0100; end
            4'h7: begin col_mask = 4'b1000; row_mask = 4'b0010; end
            4'hE: begin col_mask = 4'b1000; row_mask = 4'b0001; end
            4'h2: begin col_mask = 4'b0100; row_mask = 4'b1000; end
            4'h5: begin col_mask = 4'b0100; row_mask = 4'b0100; end
            4'h8: begin col_mask = 4'b0100; row_mask = 4'b0010; end
            4'h0: begin col_mask = 4'b0100; row_mask = 4'b0001; end
            4'h3: begin col_mask = 4'b0010; row_mask = 4'b1000; end
            4'h6: begin col_mask = 4'b0010; row_mask = 4'b0100; end
            4'h9: begin col_mask = 4'b0010; row_mask = 4'b0010; end
            4'hF: begin col_mask = 4'b0010; row_mask = 4'b0001; end
            4'hA: begin col_mask = 4'b0001; row_mask = 4'b1000; end
            4'hB: begin col_mask = 4'b0001; row_mask = 4'b0100; end
            4'hC: begin col_mask = 4'b0001; row_mask = 4'b0010; end
            default: begin col_mask = 4'b0001; row_mask = 4'b0001; end
        endcase
    end

    always_comb begin
        rows = '0;
        if ((state_q == S_PRESS) && ((cols & col_mask) != '0)) rows = row_mask;
`ifdef KEYEMU_BOUNCE_EN
        if ((bcnt_q != 3'd4) && tog_q) rows = '0;
`endif
        key_active    = (state_q == S_PRESS);
        busy          = (state_q != S_IDLE) || (count_q != '0);
        done          = done_q;
        cmd.cmd_ready = ~full;
    end
endmodule

// File: tb/tb_keypad_emulator.sv
// Self-checking bench for keypad_emulator: directed and random commands against a
// schedule model (each press start time derived from acceptance times and prior presses).
module tb_keypad_emulator;
    localparam int DEPTH = 4;
    localparam int HB    = 8;
    localparam int G     = 16;

    logic       clk1;
    logic       reset;
    logic [3:0] cols;
    logic [3:0] rows;
    logic       key_active, busy, done;

    keypad_emulator_if #(.HOLDBITS(HB)) ifc ();

    keypad_emulator #(.DEPTH(DEPTH), .HOLDBITS(HB), .GAPCYCLES(G)) dut (
        .clk1       (clk1),
        .reset      (reset),
        .cmd        (ifc),
        .cols       (cols),
        .rows       (rows),
        .key_active (key_active),
        .busy       (busy),
        .done       (done)
    );

    initial clk1 = 1'b0;
    always #5 clk1 = ~clk1;

    typedef struct {
        int a;    // edge of acceptance
        int s;    // first PRESS cycle
        int h;    // PRESS length
        int key;
    } cmd_t;

    cmd_t q[$];
    int   n_cmp = 0;
    int   n_err = 0;
    int   e     = 0;
    logic pend  = 1'b0;
    int   pk, ph;

    // columns listed bit 3 down to bit 0; rows within a column listed bit 3 down to bit 0
    int kmap[4][4] = '{'{1, 4, 7, 14}, '{2, 5, 8, 0}, '{3, 6, 9, 15}, '{10, 11, 12, 13}};

    task automatic chk(input string tag, input int unsigned got, input int unsigned exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s @%0t: got %0h expected %0h", tag, $time, got, exp);
        end
    endtask

    function automatic void key_masks(input int k, output logic [3:0] cm, output logic [3:0] rm);
        cm = '0;
        rm = '0;
        for (int i = 0; i < 4; i++)
            for (int j = 0; j < 4; j++)
                if (kmap[i][j] == k) begin
                    cm = 4'(1 << (3 - i));
                    rm = 4'(1 << (3 - j));
                end
    endfunction

    function automatic int occ(input int t);
        int n = 0;
        foreach (q[i]) if (q[i].a <= t && t < q[i].s) n++;
        return n;
    endfunction

    function automatic void accept(input int a, input int k, input int h);
        int hh;
        int s;
        hh = (h == 0) ? 1 : h;
        s  = a + 1;
        if (q.size() > 0 && q[$].s + q[$].h + G + 1 > s) s = q[$].s + q[$].h + G + 1;
        q.push_back('{a, s, hh, k});
    endfunction

    task automatic check_cycle(input int t);
        logic [3:0] er, cm, rm;
        logic       eka, edn, enid;
        int         o;
        er = '0; eka = 1'b0; edn = 1'b0; enid = 1'b0;
        foreach (q[i]) begin
            if (t >= q[i].s && t < q[i].s + q[i].h) begin
                eka = 1'b1;
                key_masks(q[i].key, cm, rm);
                if ((cols & cm) != '0) er = rm;
                o = t - q[i].s;
`ifdef KEYEMU_BOUNCE_EN
                if (o < 4 && (o % 2) == 1) er = '0;
`endif
            end
            if (t >= q[i].s && t < q[i].s + q[i].h + G) enid = 1'b1;
            if (t == q[i].s + q[i].h + G) edn = 1'b1;
        end
        chk("rows", rows, er);
        chk("key_active", key_active, eka);
        chk("done", done, edn);
        chk("busy", busy, enid || (occ(t) > 0));
        chk("cmd_ready", ifc.cmd_ready, occ(t) < DEPTH);
    endtask

    task automatic step(input int v, input int k, input int h, input int c);
        @(posedge clk1);
        e++;
        if (pend) accept(e, pk, ph);
        #1;
        ifc.cmd_valid = v[0];
        ifc.cmd_key   = 4'(k);
        ifc.cmd_hold  = HB'(h);
        cols          = 4'(c);
        @(negedge clk1);
        check_cycle(e);
        pend = v[0] && (occ(e) < DEPTH);
        pk   = k;
        ph   = h;
    endtask

    int fkeys[5] = '{3, 7, 11, 14, 2};
    int idx;

    initial begin
        reset         = 1'b1;
        ifc.cmd_valid = 1'b0;
        ifc.cmd_key   = '0;
        ifc.cmd_hold  = '0;
        cols          = '0;
        #2 reset = 1'b0;
        #1;
        chk("rst_rows", rows, 0);
        chk("rst_key_active", key_active, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_cmd_ready", ifc.cmd_ready, 1);
        @(posedge clk1);
        @(negedge clk1);
        reset = 1'b1;

        // key 5, hold 10, column 2 held active
        step(1, 5, 10, 4'b0100);
        repeat (30) step(0, 0, 0, 4'b0100);

        // key D with rotating column scan
        step(1, 13, 3, 4'b1000);
        for (int i = 0; i < 24; i++) step(0, 0, 0, 4'b1000 >> ((i + 1) % 4));

        // five commands pushed back to back into a DEPTH-4 FIFO
        idx = 0;
        for (int i = 0; i < 300 && idx < 5; i++) begin
            step(1, fkeys[idx], 6, 4'hF);
            if (pend) idx++;
        end
        chk("fill_accepted", idx, 5);
        repeat (130) step(0, 0, 0, 4'hF);

        // zero hold behaves as one cycle
        step(1, 0, 0, 4'b0100);
        repeat (20) step(0, 0, 0, 4'b0100);

        // key 1, hold 8 (bounce pattern when enabled)
        step(1, 1, 8, 4'b1000);
        repeat (28) step(0, 0, 0, 4'b1000);

        // reset mid-press with a further command queued
        step(1, 9, 20, 4'b0010);
        step(1, 3, 5, 4'b0010);
        repeat (4) step(0, 0, 0, 4'b0010);
        #2 reset = 1'b0;
        ifc.cmd_valid = 1'b0;
        #1;
        chk("midrst_rows", rows, 0);
        chk("midrst_key_active", key_active, 0);
        q.delete();
        pend = 1'b0;
        @(posedge clk1);
        @(posedge clk1);
        @(negedge clk1);
        reset = 1'b1;
        #1;
        chk("postrst_cmd_ready", ifc.cmd_ready, 1);
        chk("postrst_busy", busy, 0);
        repeat (40) step(0, 0, 0, 4'b0010);

        // randomized traffic
        for (int i = 0; i < 400; i++)
            step(($urandom_range(3) == 0) ? 1 : 0, $urandom_range(15),
                 $urandom_range(12), $urandom_range(15));
        repeat (150) step(0, 0, 0, $urandom_range(15));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
